pe_os_mac: RTL and testbench

Output-stationary processing element for the torus systolic array: multiplies streaming A (west→east) and B (north→south) operands into a resident accumulator, forwards both operands to neighbours with one-cycle latency, and on command drains its result, followed by the results of upstream PEs, down a column shift chain. Generalises the basic MAC PE with valid qualification, signed/unsigned mode, tile clear, overflow detection and a counted drain phase.

---
 rtl/pe_pkg.sv | 28 ++
 rtl/pe_sat_add.sv | 43 ++++
 rtl/pe_os_mac.sv | 144 ++++++++++++++
 tb/tb_pe_os_mac.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared types and sizing helpers for the output-stationary MAC processing element.
package pe_pkg;

  typedef enum logic [0:0] {
    PE_COMPUTE = 1'b0,
    PE_DRAIN   = 1'b1
  } pe_state_e;

  localparam int unsigned PE_DEFAULT_OPERAND_WIDTH    = 8;
  localparam int unsigned PE_DEFAULT_ACCUMULATE_WIDTH = 16;
  localparam int unsigned PE_DEFAULT_DRAIN_DEPTH      = 3;
  // The accumulator must hold a full-width product without loss.
  localparam int unsigned PE_ACC_MIN_FACTOR           = 2;

  function automatic bit acc_width_ok(input int unsigned operand_w, input int unsigned acc_w);
    return acc_w >= PE_ACC_MIN_FACTOR * operand_w;
  endfunction

  // Counter must hold DRAIN_DEPTH; kept at least one bit wide so depth 0 still elaborates.
  function automatic int unsigned drain_cnt_width(input int unsigned depth);
    int unsigned w;
    w = $clog2(depth + 1);
    return (w < 1) ? 1 : w;
  endfunction

  localparam int unsigned PE_DRAIN_CNT_W = drain_cnt_width(PE_DEFAULT_DRAIN_DEPTH);

endpackage

// File: rtl/pe_sat_add.sv
// Accumulator adder with carry/sign overflow detection; clamps on overflow
// when PE_SATURATE_EN is defined, otherwise wraps.
module pe_sat_add
  import pe_pkg::*;
#(
  parameter int unsigned WIDTH = PE_DEFAULT_ACCUMULATE_WIDTH
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] addend_i,
  input  logic             signed_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             overflow_o
);

  logic [WIDTH:0]   sum_full;
  logic [WIDTH-1:0] sum_raw;
  logic             carry_ovf;
  logic             sign_ovf;

  always_comb begin
    sum_full  = {1'b0, acc_i} + {1'b0, addend_i};
    sum_raw   = sum_full[WIDTH-1:0];
    carry_ovf = sum_full[WIDTH];
    sign_ovf  = (acc_i[WIDTH-1] == addend_i[WIDTH-1]) && (sum_raw[WIDTH-1] != acc_i[WIDTH-1]);
    overflow_o = signed_i ? sign_ovf : carry_ovf;
`ifdef PE_SATURATE_EN
    if (overflow_o) begin
      if (!signed_i) begin
        sum_o = '1;
      end else if (acc_i[WIDTH-1]) begin
        sum_o = {1'b1, {(WIDTH-1){1'b0}}};
      end else begin
        sum_o = {1'b0, {(WIDTH-1){1'b1}}};
      end
    end else begin
      sum_o = sum_raw;
    end
`else
    sum_o = sum_raw;
`endif
  end

endmodule

// File: rtl/pe_os_mac.sv
// Output-stationary MAC PE: forwards operands east/south, accumulates locally and
// drains its result followed by upstream results down the column. Option: PE_SATURATE_EN.
module pe_os_mac
  import pe_pkg::*;
#(
  parameter int unsigned OPERAND_WIDTH    = PE_DEFAULT_OPERAND_WIDTH,
  parameter int unsigned ACCUMULATE_WIDTH = PE_DEFAULT_ACCUMULATE_WIDTH,
  parameter int unsigned DRAIN_DEPTH      = PE_DEFAULT_DRAIN_DEPTH
) (
  input  logic                        clk_i,
  input  logic                        reset_n,
  input  logic [OPERAND_WIDTH-1:0]    a_i,
  input  logic                        a_valid_i,
  input  logic [OPERAND_WIDTH-1:0]    b_i,
  input  logic                        b_valid_i,
  input  logic                        signed_i,
  input  logic                        clear_i,
  input  logic                        drain_i,
  input  logic [ACCUMULATE_WIDTH-1:0] c_in_i,
  input  logic                        c_in_valid_i,
  output logic [OPERAND_WIDTH-1:0]    a_o,
  output logic                        a_valid_o,
  output logic [OPERAND_WIDTH-1:0]    b_o,
  output logic                        b_valid_o,
  output logic [ACCUMULATE_WIDTH-1:0] c_o,
  output logic                        c_valid_o,
  output logic                        overflow_o,
  output logic                        busy_o
);

  localparam int unsigned CNT_W = drain_cnt_width(DRAIN_DEPTH);
  localparam int unsigned EXT_W = ACCUMULATE_WIDTH - OPERAND_WIDTH;

  if (!acc_width_ok(OPERAND_WIDTH, ACCUMULATE_WIDTH)) begin : g_bad_acc_width
    $error("pe_os_mac: ACCUMULATE_WIDTH must be at least 2*OPERAND_WIDTH");
  end

  pe_state_e                   state_q, state_d;
  logic [CNT_W-1:0]            drain_cnt_q, drain_cnt_d;
  logic [ACCUMULATE_WIDTH-1:0] acc_q, acc_d;
  logic [ACCUMULATE_WIDTH-1:0] c_q, c_d;
  logic                        c_valid_q, c_valid_d;
  logic                        overflow_q, overflow_d;
  logic [OPERAND_WIDTH-1:0]    a_q, b_q;
  logic                        a_valid_q, b_valid_q;

  logic                        fire;
  logic [ACCUMULATE_WIDTH-1:0] a_ext, b_ext, product;
  logic [ACCUMULATE_WIDTH-1:0] acc_base, acc_sum, acc_next;
  logic                        add_ovf;

  assign fire = (state_q == PE_COMPUTE) && a_valid_i && b_valid_i;

  // Multiplying the extended operands modulo 2^ACCUMULATE_WIDTH yields the
  // correctly sign- or zero-extended full product because the width is >= 2*OPERAND_WIDTH.
  assign a_ext    = {{EXT_W{signed_i & a_i[OPERAND_WIDTH-1]}}, a_i};
  assign b_ext    = {{EXT_W{signed_i & b_i[OPERAND_WIDTH-1]}}, b_i};
  assign product  = a_ext * b_ext;
  assign acc_base = clear_i ? '0 : acc_q;

  pe_sat_add #(
    .WIDTH(ACCUMULATE_WIDTH)
  ) u_sat_add (
    .acc_i     (acc_base),
    .addend_i  (product),
    .signed_i  (signed_i),
    .sum_o     (acc_sum),
    .overflow_o(add_ovf)
  );

  assign acc_next = fire ? acc_sum : acc_base;

  // NOTE: every variable driven here gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    acc_d       = acc_q;
    c_d         = c_q;
    c_valid_d   = 1'b0;
    overflow_d  = overflow_q;
    unique case (state_q)
      PE_COMPUTE: begin
        acc_d      = acc_next;
        overflow_d = (overflow_q & ~clear_i) | (fire & add_ovf);
        if (drain_i) begin
          c_d        = acc_next;
          c_valid_d  = 1'b1;
          acc_d      = '0;
          overflow_d = 1'b0;
          if (DRAIN_DEPTH > 0) begin
            state_d     = PE_DRAIN;
            drain_cnt_d = CNT_W'(DRAIN_DEPTH);
          end
        end
      end
      PE_DRAIN: begin
        c_d         = c_in_i;
        c_valid_d   = c_in_valid_i;
        drain_cnt_d = drain_cnt_q - CNT_W'(1);
        if (drain_cnt_q == CNT_W'(1)) begin
          state_d = PE_COMPUTE;
        end
      end
      default: state_d = PE_COMPUTE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= PE_COMPUTE;
      drain_cnt_q <= '0;
      acc_q       <= '0;
      c_q         <= '0;
      c_valid_q   <= 1'b0;
      overflow_q  <= 1'b0;
      a_q         <= '0;
      a_valid_q   <= 1'b0;
      b_q         <= '0;
      b_valid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      acc_q       <= acc_d;
      c_q         <= c_d;
      c_valid_q   <= c_valid_d;
      overflow_q  <= overflow_d;
      a_q         <= a_i;
      a_valid_q   <= a_valid_i;
      b_q         <= b_i;
      b_valid_q   <= b_valid_i;
    end
  end

  assign a_o        = a_q;
  assign a_valid_o  = a_valid_q;
  assign b_o        = b_q;
  assign b_valid_o  = b_valid_q;
  assign c_o        = c_q;
  assign c_valid_o  = c_valid_q;
  assign overflow_o = overflow_q;
  assign busy_o     = (state_q == PE_DRAIN);

endmodule

// File: tb/tb_pe_os_mac.sv
// Directed self-checking bench for pe_os_mac (DRAIN_DEPTH=2); expected values are hand-computed.
module tb_pe_os_mac;

  localparam int unsigned OW = 8;
  localparam int unsigned AW = 16;
  localparam int unsigned DD = 2;

`ifdef PE_SATURATE_EN
  localparam logic [AW-1:0] EXP_SIGNED_OVF   = 16'h7FFF;
  localparam logic [AW-1:0] EXP_UNSIGNED_OVF = 16'hFFFF;
`else
  localparam logic [AW-1:0] EXP_SIGNED_OVF   = 16'hBE01;
  localparam logic [AW-1:0] EXP_UNSIGNED_OVF = 16'hFC02;
`endif

  logic          clk;
  logic          reset_n;
  logic [OW-1:0] a_i, b_i;
  logic          a_valid_i, b_valid_i;
  logic          signed_i, clear_i, drain_i;
  logic [AW-1:0] c_in_i;
  logic          c_in_valid_i;
  logic [OW-1:0] a_o, b_o;
  logic          a_valid_o, b_valid_o;
  logic [AW-1:0] c_o;
  logic          c_valid_o, overflow_o, busy_o;

  int checks;
  int failures;

  pe_os_mac #(
    .OPERAND_WIDTH   (OW),
    .ACCUMULATE_WIDTH(AW),
    .DRAIN_DEPTH     (DD)
  ) dut (
    .clk_i       (clk),
    .reset_n     (reset_n),
    .a_i         (a_i),
    .a_valid_i   (a_valid_i),
    .b_i         (b_i),
    .b_valid_i   (b_valid_i),
    .signed_i    (signed_i),
    .clear_i     (clear_i),
    .drain_i     (drain_i),
    .c_in_i      (c_in_i),
    .c_in_valid_i(c_in_valid_i),
    .a_o         (a_o),
    .a_valid_o   (a_valid_o),
    .b_o         (b_o),
    .b_valid_o   (b_valid_o),
    .c_o         (c_o),
    .c_valid_o   (c_valid_o),
    .overflow_o  (overflow_o),
    .busy_o      (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic operands(input logic [OW-1:0] a, input logic [OW-1:0] b, input logic v, input logic clr);
    a_i = a; b_i = b; a_valid_i = v; b_valid_i = v; clear_i = clr;
  endtask

  // Drain with an idle upstream chain: own word, then DD empty cycles.
  task automatic drain_own(input string tag, input logic [AW-1:0] exp);
    operands('0, '0, 1'b0, 1'b0);
    drain_i = 1'b1; c_in_i = '0; c_in_valid_i = 1'b0;
    tick();
    check({tag, "_c"}, c_o, exp);
    check({tag, "_cv"}, c_valid_o, 1);
    check({tag, "_ovf_clr"}, overflow_o, 0);
    drain_i = 1'b0;
    repeat (DD) tick();
    check({tag, "_busy_done"}, busy_o, 0);
  endtask

  initial begin
    checks = 0; failures = 0;
    reset_n = 1'b0;
    operands('0, '0, 1'b0, 1'b0);
    signed_i = 1'b0; drain_i = 1'b0; c_in_i = '0; c_in_valid_i = 1'b0;
    #12;
    check("rst_a_o", a_o, 0);
    check("rst_c_o", c_o, 0);
    check("rst_cv", c_valid_o, 0);
    check("rst_ovf", overflow_o, 0);
    check("rst_busy", busy_o, 0);
    reset_n = 1'b1;
    tick();

    // Unsigned accumulate: 2*3 with clear, then + 5*5 = 31.
    operands(8'd2, 8'd3, 1'b1, 1'b1);
    tick();
    check("fwd_a", a_o, 2);
    check("fwd_av", a_valid_o, 1);
    check("fwd_b", b_o, 3);
    check("fwd_bv", b_valid_o, 1);
    operands(8'd5, 8'd5, 1'b1, 1'b0);
    tick();

    // Drain: own word 31, then chain words 100, 200.
    operands('0, '0, 1'b0, 1'b0);
    drain_i = 1'b1; c_in_i = 16'd999; c_in_valid_i = 1'b1;
    tick();
    check("drain1_own", c_o, 31);
    check("drain1_cv", c_valid_o, 1);
    check("drain1_busy1", busy_o, 1);
    drain_i = 1'b0; c_in_i = 16'd100;
    a_i = 8'h55; a_valid_i = 1'b1;
    tick();
    check("drain1_w1", c_o, 100);
    check("drain1_busy2", busy_o, 1);
    check("drain_fwd_a", a_o, 8'h55);
    check("drain_fwd_av", a_valid_o, 1);
    c_in_i = 16'd200;
    operands(8'd7, 8'd9, 1'b1, 1'b0);
    tick();
    check("drain1_w2", c_o, 200);
    check("drain1_cv2", c_valid_o, 1);
    check("drain1_busy_end", busy_o, 0);
    operands('0, '0, 1'b0, 1'b0);
    c_in_valid_i = 1'b0; c_in_i = '0;
    tick();
    check("idle_cv", c_valid_o, 0);
    check("idle_c_hold", c_o, 200);

    // Fire during drain was ignored, so 4*4 lands on a zero accumulator.
    operands(8'd4, 8'd4, 1'b1, 1'b0);
    tick();
    drain_own("acc16", 16'd16);

    // Signed versus unsigned interpretation of the same operands.
    signed_i = 1'b1;
    operands(8'hFE, 8'h03, 1'b1, 1'b1);
    tick();
    drain_own("signed_m6", 16'hFFFA);
    signed_i = 1'b0;
    operands(8'hFE, 8'h03, 1'b1, 1'b1);
    tick();
    drain_own("unsigned_2fa", 16'h02FA);

    // Signed overflow: 0x7F00 (254*128 unsigned) + 127*127.
    signed_i = 1'b0;
    operands(8'hFE, 8'h80, 1'b1, 1'b1);
    tick();
    check("pre_ovf", overflow_o, 0);
    signed_i = 1'b1;
    operands(8'h7F, 8'h7F, 1'b1, 1'b0);
    tick();
    check("sovf_flag", overflow_o, 1);
    operands('0, '0, 1'b0, 1'b0);
    tick();
    check("sovf_sticky", overflow_o, 1);
    drain_own("sovf_val", EXP_SIGNED_OVF);

    // Unsigned carry overflow: 0xFE01 + 0xFE01.
    signed_i = 1'b0;
    operands(8'hFF, 8'hFF, 1'b1, 1'b1);
    tick();
    operands(8'hFF, 8'hFF, 1'b1, 1'b0);
    tick();
    check("uovf_flag", overflow_o, 1);
    drain_own("uovf_val", EXP_UNSIGNED_OVF);

    // clear_i without fire drops the sticky flag and the accumulator.
    operands(8'hFF, 8'hFF, 1'b1, 1'b1);
    tick();
    operands(8'hFF, 8'hFF, 1'b1, 1'b0);
    tick();
    check("ovf2_flag", overflow_o, 1);
    operands('0, '0, 1'b0, 1'b1);
    tick();
    check("clear_ovf", overflow_o, 0);
    drain_own("clear_acc", 16'd0);

    // Reset during the second drain cycle aborts the drain.
    operands(8'd6, 8'd7, 1'b1, 1'b1);
    tick();
    operands('0, '0, 1'b0, 1'b0);
    drain_i = 1'b1;
    tick();
    check("rd_own", c_o, 42);
    drain_i = 1'b0; c_in_i = 16'd100; c_in_valid_i = 1'b1;
    a_i = 8'h55; a_valid_i = 1'b1;
    tick();
    check("rd_busy_pre", busy_o, 1);
    reset_n = 1'b0;
    #1;
    check("rd_busy", busy_o, 0);
    check("rd_c", c_o, 0);
    check("rd_cv", c_valid_o, 0);
    check("rd_a", a_o, 0);
    check("rd_av", a_valid_o, 0);
    operands('0, '0, 1'b0, 1'b0);
    c_in_i = '0; c_in_valid_i = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    operands(8'd3, 8'd3, 1'b1, 1'b0);
    tick();
    drain_own("post_rst", 16'd9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
